// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the lane-parallel FFT core: streams frames from a source
// buffer into the core, collects results into a sink buffer, and flags faults.
module fft_frame_sequencer #(
  parameter  int DW    = 64,
  parameter  int LANES = 8,
  parameter  int NPTS  = 4096,
  parameter  int FW    = 8,
  parameter  int TMO   = 65535,
  localparam int BEATS = NPTS / LANES,
  localparam int BW    = $clog2(BEATS),
  localparam int AW    = FW + BW
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                REQ,
  input  logic [FW-1:0]       NFRAMES,
  output logic                BUSY,
  output logic                JOB_DONE,
  output logic                ERR,
  output logic [1:0]          ERR_CODE,
  output logic                SRC_RE,
  output logic [AW-1:0]       SRC_ADDR,
  input  logic [LANES*DW-1:0] SRC_DATA,
  output logic                FFT_START,
  output logic [LANES*DW-1:0] FFT_D,
  input  logic                FFT_DONE,
  input  logic [LANES*DW-1:0] FFT_Q,
  output logic                SNK_WE,
  output logic [AW-1:0]       SNK_ADDR,
  output logic [LANES*DW-1:0] SNK_DATA
);

  localparam int             TCW      = $clog2(TMO + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO - 1);
  localparam logic [BW:0]    BEATS_C  = (BW + 1)'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREF,
    S_LOAD,
    S_UNLOAD,
    S_CHECK
  } state_e;

  typedef enum logic [1:0] {
    E_NONE    = 2'b00,
    E_TIMEOUT = 2'b01,
    E_OVERFLW = 2'b10,
    E_SHORT   = 2'b11
  } err_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         nframes_q, nframes_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [BW-1:0]         src_beat_q, src_beat_d;
  logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [BW:0]           unl_cnt_q, unl_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  job_done_q, job_done_d;
  logic                  err_q, err_d;
  err_e                  err_code_q, err_code_d;
  logic                  src_re_q, src_re_d;
  logic                  fft_start_q, fft_start_d;
  logic                  snk_we_q, snk_we_d;
  logic [AW-1:0]         snk_addr_q, snk_addr_d;
  logic [LANES*DW-1:0]   snk_data_q, snk_data_d;
  logic                  more_frames;

  assign more_frames = ({1'b0, frame_q} + (FW + 1)'(1)) < {1'b0, nframes_q};

  always_comb begin
    state_d     = state_q;
    nframes_d   = nframes_q;
    frame_d     = frame_q;
    src_beat_d  = src_beat_q;
    tmo_cnt_d   = tmo_cnt_q;
    unl_cnt_d   = unl_cnt_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    job_done_d  = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;
    src_re_d    = 1'b0;
    fft_start_d = 1'b0;
    snk_we_d    = 1'b0;
    snk_addr_d  = snk_addr_q;
    snk_data_d  = snk_data_q;

    case (state_q)
      S_IDLE: begin
        if (REQ && (NFRAMES != '0)) begin
          state_d    = S_PREF;
          nframes_d  = NFRAMES;
          frame_d    = '0;
          src_beat_d = '0;
          err_d      = 1'b0;
          err_code_d = E_NONE;
          busy_d     = 1'b1;
          src_re_d   = 1'b1;
        end
      end

      S_PREF: begin
        // Address runs one beat ahead of FFT_D because of the read latency.
        state_d     = S_LOAD;
        fft_start_d = 1'b1;
        src_re_d    = 1'b1;
        src_beat_d  = BW'(1);
        tmo_cnt_d   = '0;
      end

      S_LOAD: begin
        if (FFT_DONE) begin
          state_d    = S_UNLOAD;
          snk_we_d   = 1'b1;
          snk_addr_d = {frame_q, {BW{1'b0}}};
          snk_data_d = FFT_Q;
          unl_cnt_d  = (BW + 1)'(1);
          ovf_d      = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
        end else begin
          fft_start_d = 1'b1;
          src_re_d    = 1'b1;
          tmo_cnt_d   = tmo_cnt_q + TCW'(1);
          if (src_beat_q != '1) begin
            src_beat_d = src_beat_q + BW'(1);
          end
        end
      end

      S_UNLOAD: begin
        if (FFT_DONE) begin
          if (unl_cnt_q < BEATS_C) begin
            snk_we_d   = 1'b1;
            snk_addr_d = {frame_q, unl_cnt_q[BW-1:0]};
            snk_data_d = FFT_Q;
            unl_cnt_d  = unl_cnt_q + (BW + 1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          // Completion pulse must be visible during CHECK, so decide it here.
          state_d    = S_CHECK;
          job_done_d = !ovf_q && (unl_cnt_q == BEATS_C) && !more_frames;
        end
      end

      S_CHECK: begin
        if (ovf_q) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = E_OVERFLW;
        end else if (unl_cnt_q != BEATS_C) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = E_SHORT;
        end else if (more_frames) begin
          state_d    = S_PREF;
          frame_d    = frame_q + FW'(1);
          src_beat_d = '0;
          src_re_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      nframes_q   <= '0;
      frame_q     <= '0;
      src_beat_q  <= '0;
      tmo_cnt_q   <= '0;
      unl_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      src_re_q    <= 1'b0;
      fft_start_q <= 1'b0;
      snk_we_q    <= 1'b0;
      snk_addr_q  <= '0;
      snk_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      nframes_q   <= nframes_d;
      frame_q     <= frame_d;
      src_beat_q  <= src_beat_d;
      tmo_cnt_q   <= tmo_cnt_d;
      unl_cnt_q   <= unl_cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      src_re_q    <= src_re_d;
      fft_start_q <= fft_start_d;
      snk_we_q    <= snk_we_d;
      snk_addr_q  <= snk_addr_d;
      snk_data_q  <= snk_data_d;
    end
  end

  assign BUSY      = busy_q;
  assign JOB_DONE  = job_done_q;
  assign ERR       = err_q;
  assign ERR_CODE  = err_code_q;
  assign SRC_RE    = src_re_q;
  assign SRC_ADDR  = {frame_q, src_beat_q};
  assign FFT_START = fft_start_q;
  assign FFT_D     = SRC_DATA;
  assign SNK_WE    = snk_we_q;
  assign SNK_ADDR  = snk_addr_q;
  assign SNK_DATA  = snk_data_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: directed job table, reset/ignore sequences and
// randomized jobs, all scored against a per-frame job model.
module tb_fft_frame_sequencer;

  localparam int DW    = 16;
  localparam int LANES = 8;
  localparam int NPTS  = 64;
  localparam int FW    = 4;
  localparam int TMO   = 100;
  localparam int BEATS = NPTS / LANES;
  localparam int AW    = FW + 3;
  localparam int WW    = LANES * DW;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b1;
  logic          REQ = 1'b0;
  logic [FW-1:0] NFRAMES = '0;
  logic [WW-1:0] SRC_DATA = '0;
  logic          FFT_DONE = 1'b0;
  logic [WW-1:0] FFT_Q = '0;
  logic          BUSY, JOB_DONE, ERR, SRC_RE, FFT_START, SNK_WE;
  logic [1:0]    ERR_CODE;
  logic [AW-1:0] SRC_ADDR, SNK_ADDR;
  logic [WW-1:0] FFT_D, SNK_DATA;

  fft_frame_sequencer #(
    .DW(DW), .LANES(LANES), .NPTS(NPTS), .FW(FW), .TMO(TMO)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .NFRAMES(NFRAMES),
    .BUSY(BUSY), .JOB_DONE(JOB_DONE), .ERR(ERR), .ERR_CODE(ERR_CODE),
    .SRC_RE(SRC_RE), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
    .FFT_START(FFT_START), .FFT_D(FFT_D), .FFT_DONE(FFT_DONE), .FFT_Q(FFT_Q),
    .SNK_WE(SNK_WE), .SNK_ADDR(SNK_ADDR), .SNK_DATA(SNK_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int nfr;
    int l0, l1, l2;
    int d0, d1, d2;
    int code;
    int nwr;
    int jd;
  } vec_t;

  int ld[16];
  int dn[16];
  int seed;
  bit req_noise;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic logic [WW-1:0] mkword(input logic [15:0] tag);
    logic [WW-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*DW +: DW] = tag ^ 16'(i * 4951);
    return w;
  endfunction

  function automatic logic [WW-1:0] qword(input int f, input int k);
    return mkword(16'(seed * 256 + f * 16 + k) | 16'h8000);
  endfunction

  function automatic logic [WW-1:0] src_word(input int a);
    return mkword(16'h5A00 ^ 16'(a % (1 << AW)));
  endfunction

  // Runs one job with per-frame DONE delay ld[] and DONE length dn[].
  task automatic run_job(input int nfr, output int o_nwr, output int o_jd, output int o_code);
    logic [AW-1:0] ea[$];
    logic [WW-1:0] ed[$];
    int ew[$];
    int e_code = 0, e_jd = 0;
    bit e_tmo = 0;
    int nwr = 0, wr_bad = 0, jd = 0, jd_cyc = -1, win_bad = 0, nwin = 0;
    int gap_bad = 0, dbad = 0, cyc = 0, st_cnt = 0, dn_rem = 0, dn_idx = 0, fr = 0;
    int last_fall = -1, last_start = -1, busy_fall = -1, b;
    logic prev_done = 1'b0, prev_start = 1'b0, pend_v = 1'b0;
    logic [WW-1:0] pend = '0;

    // Reference: walk frames, applying the timeout/overflow/short rules in order.
    for (int f = 0; f < nfr; f++) begin
      if (ld[f] > TMO) begin ew.push_back(TMO); e_code = 1; e_tmo = 1; break; end
      ew.push_back(ld[f]);
      for (int k = 0; k < dn[f] && k < BEATS; k++) begin
        ea.push_back(AW'(f * BEATS + k));
        ed.push_back(qword(f, k));
      end
      if (dn[f] > BEATS) begin e_code = 2; break; end
      if (dn[f] < BEATS) begin e_code = 3; break; end
      if (f == nfr - 1) e_jd = 1;
    end

    REQ = 1'b1;
    NFRAMES = FW'(nfr);
    @(negedge CLK);
    REQ = 1'b0;
    check("accept_busy", longint'(BUSY), 1);
    check("accept_err_clear", longint'({ERR, ERR_CODE}), 0);
    check("pref_read_base", longint'(SRC_RE && SRC_ADDR == '0 && !FFT_START), 1);

    while (busy_fall < 0 && cyc < 4000) begin
      if (pend_v) SRC_DATA = pend;
      pend_v = SRC_RE;
      if (SRC_RE) pend = src_word(int'(SRC_ADDR));
      #1;
      if (SNK_WE) begin
        if (nwr >= ea.size() || SNK_ADDR !== ea[nwr] || SNK_DATA !== ed[nwr]) wr_bad++;
        nwr++;
      end
      if (JOB_DONE) begin
        jd++;
        jd_cyc = cyc;
        if (!BUSY) wr_bad++;
      end
      if (FFT_START) begin
        if (!prev_start) begin
          nwin++;
          st_cnt = 0;
          if (last_fall >= 0 && cyc - last_fall != 3) gap_bad++;
        end
        b = (st_cnt < BEATS - 1) ? st_cnt : BEATS - 1;
        if (FFT_D !== src_word(fr * BEATS + b)) dbad++;
        st_cnt++;
        last_start = cyc;
      end else if (prev_start) begin
        if (nwin > ew.size() || st_cnt != ew[nwin-1]) win_bad++;
      end
      prev_start = FFT_START;

      FFT_DONE = 1'b0;
      if (dn_rem > 0) begin
        FFT_DONE = 1'b1;
        FFT_Q = qword(fr, dn_idx);
        dn_idx++;
        dn_rem--;
        if (dn_rem == 0) fr++;
      end else if (FFT_START && st_cnt == ld[fr]) begin
        FFT_DONE = 1'b1;
        FFT_Q = qword(fr, 0);
        dn_idx = 1;
        dn_rem = dn[fr] - 1;
        if (dn_rem == 0) fr++;
      end
      if (prev_done && !FFT_DONE) last_fall = cyc;
      prev_done = FFT_DONE;

      if (!BUSY) begin
        busy_fall = cyc;
        REQ = 1'b0;
      end else begin
        if (req_noise) begin
          REQ = 1'($urandom_range(0, 1));
          NFRAMES = FW'($urandom);
        end
        @(negedge CLK);
        cyc++;
      end
    end

    check("job_ends_in_budget", longint'(busy_fall >= 0), 1);
    check("sink_writes", nwr, ea.size());
    check("sink_content_bad", wr_bad, 0);
    check("err_code", longint'(ERR_CODE), e_code);
    check("err_flag", longint'(ERR), longint'(e_code != 0));
    check("job_done_pulses", jd, e_jd);
    check("start_windows", nwin, ew.size());
    check("start_window_len_bad", win_bad, 0);
    check("frame_gap_bad", gap_bad, 0);
    check("fft_d_beat_bad", dbad, 0);
    if (e_tmo) check("busy_fall_after_tmo", busy_fall - last_start, 1);
    else       check("busy_fall_after_done", busy_fall - last_fall, 2);
    if (e_jd != 0) check("job_done_then_idle", busy_fall - jd_cyc, 1);
    o_nwr = nwr;
    o_jd = jd;
    o_code = int'(ERR_CODE);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int o_nwr, o_jd, o_code, st, bad, seen, nfr;

    tbl[0] = '{1, 20, 0, 0, 8, 0, 0, 0, 8, 1};
    tbl[1] = '{3, 20, 5, 12, 8, 8, 8, 0, 24, 1};
    tbl[2] = '{1, 20, 0, 0, 10, 0, 0, 2, 8, 0};
    tbl[3] = '{3, 20, 20, 20, 8, 5, 8, 3, 13, 0};
    tbl[4] = '{1, 1000, 0, 0, 8, 0, 0, 1, 0, 0};
    tbl[5] = '{2, 1, 100, 0, 8, 8, 0, 0, 16, 1};
    tbl[6] = '{2, 3, 101, 0, 8, 8, 0, 1, 8, 0};

    #2 RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_ctrl", longint'({BUSY, JOB_DONE, ERR, ERR_CODE, SRC_RE, FFT_START, SNK_WE}), 0);
    check("reset_addr_data", longint'(SRC_ADDR == '0 && SNK_ADDR == '0 && SNK_DATA == '0), 1);
    RSTn = 1'b1;
    @(negedge CLK);

    req_noise = 0;
    for (int i = 0; i < 7; i++) begin
      seed = i + 1;
      ld[0] = tbl[i].l0; ld[1] = tbl[i].l1; ld[2] = tbl[i].l2;
      dn[0] = tbl[i].d0; dn[1] = tbl[i].d1; dn[2] = tbl[i].d2;
      run_job(tbl[i].nfr, o_nwr, o_jd, o_code);
      check("tbl_err_code", o_code, tbl[i].code);
      check("tbl_writes", o_nwr, tbl[i].nwr);
      check("tbl_job_done", o_jd, tbl[i].jd);
      @(negedge CLK);
    end

    // NFRAMES=0 request must be ignored.
    REQ = 1'b1;
    NFRAMES = '0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (BUSY || SRC_RE) bad++;
    end
    REQ = 1'b0;
    check("nframes_zero_ignored", bad, 0);

    // Asynchronous reset in the middle of UNLOAD.
    REQ = 1'b1;
    NFRAMES = FW'(2);
    @(negedge CLK);
    REQ = 1'b0;
    st = 0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (SNK_WE) begin seen = 1; break; end
      if (FFT_START) st++;
      FFT_DONE = (st >= 4);
      @(negedge CLK);
    end
    check("reached_unload", seen, 1);
    RSTn = 1'b0;
    #1;
    check("midjob_reset_ctrl", longint'({BUSY, JOB_DONE, ERR, ERR_CODE, SRC_RE, FFT_START, SNK_WE}), 0);
    check("midjob_reset_data", longint'(SRC_ADDR == '0 && SNK_ADDR == '0 && SNK_DATA == '0), 1);
    FFT_DONE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (BUSY || JOB_DONE || SNK_WE) bad++;
    end
    check("post_reset_quiet", bad, 0);

    seed = 50;
    ld[0] = 7;
    dn[0] = 8;
    run_job(1, o_nwr, o_jd, o_code);
    check("recover_job_done", o_jd, 1);
    @(negedge CLK);

    // Randomized jobs with REQ/NFRAMES noise while busy.
    req_noise = 1;
    for (int j = 0; j < 10; j++) begin
      seed = 100 + j;
      nfr = (j == 0) ? 15 : $urandom_range(1, 15);
      for (int f = 0; f < 16; f++) begin
        int r;
        r = $urandom_range(0, 29);
        ld[f] = $urandom_range(1, 60);
        dn[f] = BEATS;
        if (r == 0) ld[f] = 1000;
        else if (r == 1) dn[f] = $urandom_range(1, 12);
      end
      run_job(nfr, o_nwr, o_jd, o_code);
      @(negedge CLK);
    end
    req_noise = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
